apb_uart_regif: RTL and testbench
=================================

Name: apb_uart_regif

Overview:
Parametrised APB4 slave that fronts the UART register block.
- Adds over the previous APB front-end: configurable bus and register widths, programmable wait states, byte strobes, and full address/access decoding with pslverr.
- Adds sticky status flags with write-1-to-clear (W1C), an interrupt output, and single-cycle strobes to the TX/RX datapath.
- Sits between the APB fabric and the UART TX/RX cores.

Parameters:
ADDR_W, 13, APB address width; decode uses paddr[4:0], upper bits must be zero.
DATA_W, 32, APB data width; legal values are 8, 16, 32.
REG_W, 8, UART register width; REG_W <= DATA_W.
WAIT_STATES, 0, extra ACCESS cycles with pready low before completion; range 0..15.

Ports:
pclk  in  1  APB clock
presetn  in  1  asynchronous reset, active-low
psel  in  1  slave select
penable  in  1  access phase
pwrite  in  1  1 = write
paddr  in  ADDR_W  byte address
pwdata  in  DATA_W  write data
pstrb  in  DATA_W/8  byte strobes
prdata  out  DATA_W  read data
pready  out  1  transfer complete
pslverr  out  1  error, valid only with pready
tx_data  out  REG_W  TXDATA register
tx_start  out  1  one-cycle pulse: send tx_data
rx_data  in  REG_W  received byte
rx_rd  out  1  one-cycle pulse: rx_data consumed
ctrl  out  REG_W  CTRL register; bits[2:0] are irq enables
cfg  out  REG_W  CFG register (baud/parity, opaque here)
tx_busy  in  1  TX core busy (level)
tx_done  in  1  pulse
rx_done  in  1  pulse
parity_err  in  1  pulse
irq  out  1  level interrupt

Behaviour:
- Reset state: clock is pclk; reset presetn is asynchronous, active-low. While reset is asserted all outputs are 0, all registers are 0, and the FSM is in IDLE.
- Register map:
  - 0x00 TXDATA, write-only; reads return 0.
  - 0x04 RXDATA, read-only.
  - 0x08 CTRL, read/write.
  - 0x0C CFG, read/write.
  - 0x10 STATUS: bits[2:0] W1C, bit[3] = tx_busy (live, read-only).
  - STATUS bit 0 = tx_done sticky, bit 1 = rx_done sticky, bit 2 = parity_err sticky.
- FSM has two states, IDLE and ACCESS.
  - IDLE -> ACCESS on psel & !penable (setup phase). The address is decoded, the error flag computed, and the wait counter loaded with WAIT_STATES.
  - ACCESS: pready = (cnt == 0), combinational from state and counter. cnt decrements each cycle while nonzero.
  - Completion occurs on psel & penable & pready. Commit side effects in that cycle, then go to IDLE. Back-to-back transfers are re-entered via IDLE (minimum 2 cycles per transfer).
  - If psel drops in ACCESS before completion: abort to IDLE with no side effects.
- Error conditions, with pslverr = 1 at completion:
  - unmapped offset
  - paddr[1:0] != 0
  - nonzero paddr[ADDR_W-1:5]
  - write to RXDATA
  - write to TXDATA while tx_busy = 1
  - write with pstrb[0] = 0 to any register
- An errored transfer has no side effects and prdata = 0.
- Write effects:
  - Only lane 0 is used; bits above REG_W are ignored.
  - TXDATA: tx_data is loaded, and tx_start pulses in the cycle after completion.
  - CTRL/CFG: loaded at completion.
  - STATUS: bits set in pwdata[2:0] clear the matching sticky flags.
- Read effects:
  - prdata = zero-extended register, valid while pready is high; 0 otherwise.
  - A successful RXDATA read pulses rx_rd the cycle after completion and clears sticky rx_done.
- Sticky flags:
  - Each flag sets on its input pulse.
  - A set and a clear (W1C or RXDATA read) in the same cycle: set wins.
- irq = |(status[2:0] & ctrl[2:0]), registered, one-cycle latency.
- Reset mid-transfer: the FSM returns to IDLE immediately and no pulses are emitted.

Decomposition:
- Package apb_uart_pkg holds:
  - offset constants ADDR_TXDATA..ADDR_STATUS
  - status bit indices ST_TXDONE, ST_RXDONE, ST_PERR, ST_BUSY
  - FSM state enum {IDLE, ACCESS}
- Sub-module apb_uart_status: sticky flag register with set-priority W1C and the irq register. Inputs: set pulses, clear mask, clear-valid, enables.

Test Plan:
- WAIT_STATES = 2; write 0x0000_0041 to 0x00 with tx_busy = 0 -> pready low for 2 ACCESS cycles, then high with pslverr = 0; tx_data = 0x41; tx_start high for exactly 1 cycle after completion.
- Write to 0x00 with tx_busy = 1 -> pslverr = 1, tx_data unchanged, no tx_start pulse. Read 0x10 -> prdata = 0x8.
- rx_done pulse with rx_data = 0x5A; read 0x04 -> prdata = 0x5A, rx_rd pulse, STATUS bit 1 clears. A read issued on the same cycle as a new rx_done pulse leaves bit 1 set.
- parity_err pulse with ctrl = 0x4 -> irq = 1 one cycle later. Write 0x4 to 0x10 -> flag cleared and irq = 0 one cycle after commit. Write 0x4 on the same cycle as a new parity_err pulse -> flag stays set.
- Error accesses:
  - read 0x14 -> pslverr = 1, prdata = 0
  - write to 0x0A (misaligned) -> pslverr = 1
  - write 0x33 to 0x08 with pstrb = 0 -> pslverr = 1, ctrl unchanged
  - write to 0x04 -> pslverr = 1
- Drop psel mid-ACCESS with WAIT_STATES = 3 -> no register change. Assert presetn low mid-ACCESS -> all outputs 0, FSM in IDLE, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART register front-end: register offsets,
// STATUS bit positions and the transfer FSM state type.
package apb_uart_pkg;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL   = 5'h08;
  localparam logic [4:0] ADDR_CFG    = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam int ST_TXDONE = 0;
  localparam int ST_RXDONE = 1;
  localparam int ST_PERR   = 2;
  localparam int ST_BUSY   = 3;
  localparam int N_FLAGS   = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  function automatic logic is_mapped(input logic [4:0] off);
    case (off)
      ADDR_TXDATA, ADDR_RXDATA, ADDR_CTRL, ADDR_CFG, ADDR_STATUS: is_mapped = 1'b1;
      default:                                                    is_mapped = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/apb_uart_status.sv
// Sticky UART event flags with write-1-to-clear and a registered interrupt.
// A set pulse always beats a clear landing in the same cycle.
module apb_uart_status
  import apb_uart_pkg::*;
(
  input  logic               pclk,
  input  logic               presetn,
  input  logic [N_FLAGS-1:0] set_pulse,
  input  logic [N_FLAGS-1:0] clr_mask,
  input  logic               clr_valid,
  input  logic [N_FLAGS-1:0] irq_en,
  output logic [N_FLAGS-1:0] status,
  output logic               irq
);

  logic [N_FLAGS-1:0] flags_d;

  always_comb begin
    flags_d = status & ~(clr_valid ? clr_mask : {N_FLAGS{1'b0}});
    flags_d = flags_d | set_pulse;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      status <= '0;
      irq    <= 1'b0;
    end else begin
      status <= flags_d;
      irq    <= |(status & irq_en);
    end
  end

endmodule

// File: rtl/apb_uart_regif.sv
// APB4 slave fronting the UART register block: address/access decode with
// pslverr, programmable wait states, sticky status and TX/RX strobes.
module apb_uart_regif
  import apb_uart_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32,
  parameter int REG_W       = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic [REG_W-1:0]    tx_data,
  output logic                tx_start,
  input  logic [REG_W-1:0]    rx_data,
  output logic                rx_rd,
  output logic [REG_W-1:0]    ctrl,
  output logic [REG_W-1:0]    cfg,
  input  logic                tx_busy,
  input  logic                tx_done,
  input  logic                rx_done,
  input  logic                parity_err,
  output logic                irq,
  output state_t              fsm_state
);

  // Handshake: a transfer is set up by psel & !penable, then held in ACCESS
  // with psel & penable until pready; it completes (and commits) on the
  // cycle where psel & penable & pready are all high. Dropping psel earlier
  // abandons the transfer without side effects.

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic [4:0]          off_q;
  logic                wr_q;
  logic                err_q;
  logic                complete;
  logic                setup;
  logic                setup_err;
  logic [4:0]          off;
  logic [7:0]          lane0;
  logic [REG_W-1:0]    wr_val;
  logic                ok_wr, ok_rd;
  logic [N_FLAGS-1:0]  status_q;
  logic [N_FLAGS-1:0]  st_set;
  logic [N_FLAGS-1:0]  st_clr_mask;
  logic                st_clr_valid;
  logic [DATA_W-1:0]   rd_val;
  logic                unused_bits;

  assign off    = paddr[4:0];
  assign lane0  = pwdata[7:0];
  assign wr_val = REG_W'(lane0);
  assign setup  = (state_q == IDLE) && psel && !penable;
  assign unused_bits = ^{pwdata, pstrb};

  always_comb begin
    setup_err = (|(paddr >> 5)) || (off[1:0] != 2'b00) || !is_mapped(off);
    if (pwrite) begin
      if (off == ADDR_RXDATA)             setup_err = 1'b1;
      if (off == ADDR_TXDATA && tx_busy)  setup_err = 1'b1;
      if (!pstrb[0])                      setup_err = 1'b1;
    end
  end

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (psel && !penable) state_d = ACCESS;
      ACCESS:  if (!psel || complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    pready   = 1'b0;
    complete = 1'b0;
    if (state_q == ACCESS) begin
      pready   = (cnt_q == 4'd0);
      complete = psel && penable && (cnt_q == 4'd0);
    end
  end

  assign fsm_state = state_q;
  assign pslverr   = pready && err_q;
  assign ok_wr     = complete && wr_q && !err_q;
  assign ok_rd     = complete && !wr_q && !err_q;

  // Decode is captured once in the setup phase and held through ACCESS.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
      off_q <= '0;
      wr_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (setup) begin
      cnt_q <= 4'(WAIT_STATES);
      off_q <= off;
      wr_q  <= pwrite;
      err_q <= setup_err;
    end else if (state_q == ACCESS && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_data  <= '0;
      ctrl     <= '0;
      cfg      <= '0;
      tx_start <= 1'b0;
      rx_rd    <= 1'b0;
    end else begin
      tx_start <= ok_wr && (off_q == ADDR_TXDATA);
      rx_rd    <= ok_rd && (off_q == ADDR_RXDATA);
      if (ok_wr && off_q == ADDR_TXDATA) tx_data <= wr_val;
      if (ok_wr && off_q == ADDR_CTRL)   ctrl    <= wr_val;
      if (ok_wr && off_q == ADDR_CFG)    cfg     <= wr_val;
    end
  end

  always_comb begin
    st_set               = '0;
    st_set[ST_TXDONE]    = tx_done;
    st_set[ST_RXDONE]    = rx_done;
    st_set[ST_PERR]      = parity_err;
    st_clr_mask          = '0;
    if (wr_q) st_clr_mask = lane0[N_FLAGS-1:0];
    else      st_clr_mask[ST_RXDONE] = 1'b1;
    st_clr_valid = (ok_wr && off_q == ADDR_STATUS) || (ok_rd && off_q == ADDR_RXDATA);
  end

  apb_uart_status u_status (
    .pclk      (pclk),
    .presetn   (presetn),
    .set_pulse (st_set),
    .clr_mask  (st_clr_mask),
    .clr_valid (st_clr_valid),
    .irq_en    (ctrl[N_FLAGS-1:0]),
    .status    (status_q),
    .irq       (irq)
  );

  always_comb begin
    rd_val = '0;
    case (off_q)
      ADDR_RXDATA: rd_val[REG_W-1:0] = rx_data;
      ADDR_CTRL:   rd_val[REG_W-1:0] = ctrl;
      ADDR_CFG:    rd_val[REG_W-1:0] = cfg;
      ADDR_STATUS: begin
        rd_val[N_FLAGS-1:0] = status_q;
        rd_val[ST_BUSY]     = tx_busy;
      end
      default:     rd_val = '0;
    endcase
  end

  assign prdata = (pready && !wr_q && !err_q) ? rd_val : '0;

endmodule

// File: tb/tb_apb_uart_regif.sv
// Self-checking bench for apb_uart_regif: one instance with two wait states
// and one with three, sharing the APB bus and UART-side inputs.
module tb_apb_uart_regif;
  import apb_uart_pkg::*;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int REG_W  = 8;
  localparam int SW     = DATA_W / 8;

  logic                pclk = 1'b0;
  logic                presetn = 1'b0;
  logic                psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [ADDR_W-1:0]   paddr = '0;
  logic [DATA_W-1:0]   pwdata = '0;
  logic [SW-1:0]       pstrb = '0;
  logic [REG_W-1:0]    rx_data = '0;
  logic                tx_busy = 1'b0, tx_done = 1'b0, rx_done = 1'b0, parity_err = 1'b0;
  logic                use3 = 1'b0;

  logic [DATA_W-1:0]   prdata_a, prdata_b;
  logic                pready_a, pready_b, pslverr_a, pslverr_b;
  logic [REG_W-1:0]    tx_data_a, tx_data_b, ctrl_a, ctrl_b, cfg_a, cfg_b;
  logic                tx_start_a, tx_start_b, rx_rd_a, rx_rd_b, irq_a, irq_b;
  state_t              fsm_a, fsm_b, fsm_m;
  logic                psel_a, psel_b;

  assign psel_a = psel && !use3;
  assign psel_b = psel && use3;

  wire [DATA_W-1:0] prdata_m   = use3 ? prdata_b   : prdata_a;
  wire              pready_m   = use3 ? pready_b   : pready_a;
  wire              pslverr_m  = use3 ? pslverr_b  : pslverr_a;
  wire [REG_W-1:0]  tx_data_m  = use3 ? tx_data_b  : tx_data_a;
  wire              tx_start_m = use3 ? tx_start_b : tx_start_a;
  wire              rx_rd_m    = use3 ? rx_rd_b    : rx_rd_a;
  wire [REG_W-1:0]  ctrl_m     = use3 ? ctrl_b     : ctrl_a;
  wire [REG_W-1:0]  cfg_m      = use3 ? cfg_b      : cfg_a;
  wire              irq_m      = use3 ? irq_b      : irq_a;
  assign fsm_m = use3 ? fsm_b : fsm_a;

  apb_uart_regif #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_W(REG_W), .WAIT_STATES(2)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a), .pready(pready_a),
    .pslverr(pslverr_a), .tx_data(tx_data_a), .tx_start(tx_start_a), .rx_data(rx_data),
    .rx_rd(rx_rd_a), .ctrl(ctrl_a), .cfg(cfg_a), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_done(rx_done), .parity_err(parity_err), .irq(irq_a), .fsm_state(fsm_a)
  );

  apb_uart_regif #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_W(REG_W), .WAIT_STATES(3)) dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b), .tx_data(tx_data_b), .tx_start(tx_start_b), .rx_data(rx_data),
    .rx_rd(rx_rd_b), .ctrl(ctrl_b), .cfg(cfg_b), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_done(rx_done), .parity_err(parity_err), .irq(irq_b), .fsm_state(fsm_b)
  );

  // Clock / reset
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int n_cmp = 0;
  int n_err = 0;
  int last_waits = 0;
  logic [DATA_W:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer; pulses drives {parity_err, rx_done, tx_done} in the
  // completing cycle. Returns at the negedge after completion.
  task automatic apb(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic [SW-1:0] s, input bit exp_err, input logic [DATA_W-1:0] exp_rd,
                     input logic [2:0] pulses);
    logic [DATA_W:0] e;
    int  waits;
    bit  done;
    exp_q.push_back({exp_err, exp_rd});
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (pready_m) done = 1'b1;
      else begin
        waits++;
        @(negedge pclk);
      end
    end
    e = exp_q.pop_front();
    if (!done) begin
      check($sformatf("timeout@%0h", a), 64'd0, 64'd1);
    end else begin
      {parity_err, rx_done, tx_done} = pulses;
      check($sformatf("pslverr@%0h", a), 64'(pslverr_m), 64'(e[DATA_W]));
      if (!wr) check($sformatf("prdata@%0h", a), 64'(prdata_m), 64'(e[DATA_W-1:0]));
    end
    last_waits = waits;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    {parity_err, rx_done, tx_done} = 3'b000;
  endtask

  task automatic wr_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit err);
    apb(1'b1, a, d, {SW{1'b1}}, err, '0, 3'b000);
  endtask

  task automatic rd_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input bit err);
    apb(1'b0, a, '0, '0, err, exp, 3'b000);
  endtask

  task automatic pulse(input logic [2:0] p);
    @(negedge pclk);
    {parity_err, rx_done, tx_done} = p;
    @(negedge pclk);
    {parity_err, rx_done, tx_done} = 3'b000;
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    bit seen;

    // Reset state
    repeat (2) @(negedge pclk);
    check("rst_prdata", 64'(prdata_a), 64'd0);
    check("rst_pready", 64'(pready_a), 64'd0);
    check("rst_pslverr", 64'(pslverr_a), 64'd0);
    check("rst_tx_data", 64'(tx_data_a), 64'd0);
    check("rst_pulses", 64'({tx_start_a, rx_rd_a, irq_a}), 64'd0);
    check("rst_ctrl_cfg", 64'({ctrl_a, cfg_a}), 64'd0);
    check("rst_fsm", 64'(fsm_a), 64'(IDLE));
    presetn = 1'b1;

    // TXDATA write with wait states
    wr_reg(13'h00, 32'h0000_0041, 1'b0);
    check("tx_waits", 64'(last_waits), 64'd2);
    check("tx_data", 64'(tx_data_m), 64'h41);
    check("tx_start_hi", 64'(tx_start_m), 64'd1);
    @(negedge pclk);
    check("tx_start_lo", 64'(tx_start_m), 64'd0);

    // TXDATA write while busy
    tx_busy = 1'b1;
    wr_reg(13'h00, 32'h77, 1'b1);
    check("busy_tx_start", 64'(tx_start_m), 64'd0);
    check("busy_tx_data", 64'(tx_data_m), 64'h41);
    rd_reg(13'h10, 32'h8, 1'b0);
    tx_busy = 1'b0;

    // RXDATA read clears rx_done; coincident set wins
    rx_data = 8'h5A;
    pulse(3'b010);
    rd_reg(13'h10, 32'h2, 1'b0);
    rd_reg(13'h04, 32'h5A, 1'b0);
    check("rx_rd_hi", 64'(rx_rd_m), 64'd1);
    @(negedge pclk);
    check("rx_rd_lo", 64'(rx_rd_m), 64'd0);
    rd_reg(13'h10, 32'h0, 1'b0);
    apb(1'b0, 13'h04, '0, '0, 1'b0, 32'h5A, 3'b010);
    rd_reg(13'h10, 32'h2, 1'b0);

    // Parity error interrupt and W1C
    wr_reg(13'h10, 32'h7, 1'b0);
    rd_reg(13'h10, 32'h0, 1'b0);
    wr_reg(13'h08, 32'h4, 1'b0);
    @(negedge pclk);
    parity_err = 1'b1;
    @(negedge pclk);
    parity_err = 1'b0;
    check("irq_lat0", 64'(irq_m), 64'd0);
    @(negedge pclk);
    check("irq_set", 64'(irq_m), 64'd1);
    wr_reg(13'h10, 32'h4, 1'b0);
    @(negedge pclk);
    check("irq_clr", 64'(irq_m), 64'd0);
    rd_reg(13'h10, 32'h0, 1'b0);
    apb(1'b1, 13'h10, 32'h4, {SW{1'b1}}, 1'b0, '0, 3'b100);
    rd_reg(13'h10, 32'h4, 1'b0);
    check("irq_kept", 64'(irq_m), 64'd1);
    wr_reg(13'h10, 32'h3, 1'b0);
    rd_reg(13'h10, 32'h4, 1'b0);
    pulse(3'b001);
    rd_reg(13'h10, 32'h5, 1'b0);
    wr_reg(13'h10, 32'h7, 1'b0);
    rd_reg(13'h10, 32'h0, 1'b0);

    // Error accesses
    rd_reg(13'h14, 32'h0, 1'b1);
    wr_reg(13'h0A, 32'h12, 1'b1);
    apb(1'b1, 13'h08, 32'h33, '0, 1'b1, '0, 3'b000);
    rd_reg(13'h08, 32'h4, 1'b0);
    wr_reg(13'h04, 32'h55, 1'b1);
    rd_reg(13'h1008, 32'h0, 1'b1);
    rd_reg(13'h00, 32'h0, 1'b0);

    // Random CTRL/CFG traffic; only lane 0 lands
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      a = ($urandom_range(0, 1) == 0) ? 13'h08 : 13'h0C;
      wr_reg(a, d, 1'b0);
      rd_reg(a, {24'h0, d[7:0]}, 1'b0);
    end

    // Three-wait-state instance: aborted transfers
    use3 = 1'b1;
    wr_reg(13'h08, 32'h11, 1'b0);
    check("ws3_waits", 64'(last_waits), 64'd3);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h08; pwdata = 32'h22; pstrb = '1;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    check("abort_pready", 64'(pready_m), 64'd0);
    psel = 1'b0; penable = 1'b0;
    repeat (4) @(negedge pclk);
    check("abort_ctrl", 64'(ctrl_m), 64'h11);
    check("abort_fsm", 64'(fsm_m), 64'(IDLE));
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h00; pwdata = 32'h99;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      if (tx_start_m) seen = 1'b1;
    end
    check("abort_tx_start", 64'(seen), 64'd0);
    check("abort_tx_data", 64'(tx_data_m), 64'h0);

    // Reset in the middle of ACCESS
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h0C; pwdata = 32'h66;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    check("mid_rst_fsm", 64'(fsm_m), 64'(IDLE));
    check("mid_rst_outs", 64'({pready_m, pslverr_m, tx_start_m, rx_rd_m, irq_m}), 64'd0);
    check("mid_rst_regs", 64'({prdata_m, tx_data_m, ctrl_m, cfg_m}), 64'd0);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    presetn = 1'b1;
    wr_reg(13'h0C, 32'h5A, 1'b0);
    rd_reg(13'h0C, 32'h5A, 1'b0);
    rd_reg(13'h08, 32'h0, 1'b0);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
